// File: rtl/seq_frame_tx.sv
// ---------------------------------------------------------------------------
// seq_frame_tx
//
// Serial frame transmitter feeding the 1011 sequence detector. A payload word
// is accepted over a valid/ready handshake and sent one bit per clock as:
//   1011 preamble | payload MSB-first (zero-stuffed) | GAP_BITS idle zeros
// Stuffing keeps 1011 from ever appearing outside the preamble: whenever a
// non-final payload bit leaves the emitted-bit history at 101, a 0 is
// inserted before the next payload bit.
//
// Parameters
//   DATA_W    payload width, 1..32
//   GAP_BITS  trailing zero bits per frame, 1..15
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   data_in     payload word, sampled on the handshake cycle
//   data_valid  payload available
//   data_ready  transmitter idle and not in reset (combinational)
//   out_bit     serial bit (registered, 0 whenever out_valid is 0)
//   out_valid   out_bit belongs to a frame (registered)
//   busy        frame in progress (state != IDLE)
//   frame_done  one-cycle pulse coinciding with the last gap bit (registered)
// ---------------------------------------------------------------------------
module seq_frame_tx #(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_PAYLOAD  = 3'd2,
    S_STUFF    = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  // Payload bit counter must be able to hold DATA_W itself.
  localparam int              BCW         = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0]  LAST_BIT    = BCW'(DATA_W);
  localparam logic [3:0]      GAP_LAST    = 4'(GAP_BITS);
  localparam logic [3:0]      PRE_PATTERN = 4'b1011;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t            r_state;
  logic [DATA_W-1:0] r_shift;     // remaining payload, MSB is next to send
  logic [BCW-1:0]    r_bit_cnt;   // payload bits emitted so far (incl. current)
  logic [3:0]        r_cnt;       // preamble index (0..3) or gap count (1..GAP_BITS)
  logic [2:0]        r_hist;      // last three tracked bits, incl. the one on out_bit
  logic              r_out_bit;
  logic              r_out_valid;
  logic              r_frame_done;

  // -------------------------------------------------------------------------
  // Next-state / next-output wires
  // -------------------------------------------------------------------------
  state_t            w_state_next;
  logic [DATA_W-1:0] w_shift_next;
  logic [BCW-1:0]    w_bit_cnt_next;
  logic [3:0]        w_cnt_next;
  logic [2:0]        w_hist_next;
  logic              w_out_bit_next;
  logic              w_out_valid_next;
  logic              w_frame_done_next;

  logic              w_handshake;
  logic              w_pre_last;
  logic              w_pay_last;
  logic              w_need_stuff;
  logic              w_gap_last;
  logic [1:0]        w_pre_idx;
  logic [2:0]        w_hist_base;

  assign data_ready   = (r_state == S_IDLE) && !reset;
  assign w_handshake  = data_valid && data_ready;

  assign w_pre_last   = (r_cnt == 4'd3);
  assign w_pay_last   = (r_bit_cnt == LAST_BIT);
  // A stuff bit is only needed when another payload bit is still to come;
  // after the final bit the gap zeros already break any 1011.
  assign w_need_stuff = (r_hist == 3'b101) && !w_pay_last;
  assign w_gap_last   = (r_cnt == GAP_LAST);

  // Preamble bit i is PRE_PATTERN[3-i]; the next bit has index r_cnt+1.
  assign w_pre_idx    = 2'd2 - r_cnt[1:0];

  // History restarts from 000 at the handshake so a previous frame can never
  // influence the stuffing decisions of the next one.
  assign w_hist_base  = (r_state == S_IDLE) ? 3'b000 : r_hist;

  // -------------------------------------------------------------------------
  // Process 1: state and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_cnt        <= '0;
      r_hist       <= 3'b000;
      r_out_bit    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_cnt        <= w_cnt_next;
      r_hist       <= w_hist_next;
      r_out_bit    <= w_out_bit_next;
      r_out_valid  <= w_out_valid_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_handshake) begin
          w_state_next = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (w_pre_last) begin
          w_state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_pay_last) begin
          w_state_next = S_GAP;
        end else if (w_need_stuff) begin
          w_state_next = S_STUFF;
        end
      end
      S_STUFF: begin
        w_state_next = S_PAYLOAD;
      end
      S_GAP: begin
        if (w_gap_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Process 3: output / datapath logic
  // Computes what the registers will hold once w_state_next is entered, so
  // every output is registered and changes on the same edge as the state.
  // -------------------------------------------------------------------------
  always_comb begin
    w_shift_next      = r_shift;
    w_bit_cnt_next    = r_bit_cnt;
    w_cnt_next        = r_cnt;
    w_hist_next       = r_hist;
    w_out_bit_next    = 1'b0;
    w_out_valid_next  = 1'b0;
    w_frame_done_next = 1'b0;

    case (w_state_next)
      S_PREAMBLE: begin
        w_out_valid_next = 1'b1;
        if (r_state == S_IDLE) begin
          // Handshake edge: latch payload and start the preamble.
          w_shift_next   = data_in;
          w_bit_cnt_next = '0;
          w_cnt_next     = 4'd0;
          w_out_bit_next = PRE_PATTERN[3];
        end else begin
          w_cnt_next     = r_cnt + 4'd1;
          w_out_bit_next = PRE_PATTERN[w_pre_idx];
        end
        w_hist_next = {w_hist_base[1:0], w_out_bit_next};
      end

      S_PAYLOAD: begin
        w_out_valid_next = 1'b1;
        w_out_bit_next   = r_shift[DATA_W-1];
        w_shift_next     = r_shift << 1;
        w_bit_cnt_next   = r_bit_cnt + 1'b1;
        w_hist_next      = {r_hist[1:0], w_out_bit_next};
      end

      S_STUFF: begin
        // Stuff bit is tracked in the history but consumes no payload.
        w_out_valid_next = 1'b1;
        w_out_bit_next   = 1'b0;
        w_hist_next      = {r_hist[1:0], 1'b0};
      end

      S_GAP: begin
        // Gap bits are not tracked in the history.
        w_out_valid_next  = 1'b1;
        w_out_bit_next    = 1'b0;
        w_cnt_next        = (r_state == S_GAP) ? (r_cnt + 4'd1) : 4'd1;
        w_frame_done_next = (w_cnt_next == GAP_LAST);
      end

      default: begin
        // IDLE: outputs stay low.
      end
    endcase
  end

  assign out_bit    = r_out_bit;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_seq_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_frame_tx
//
// Directed bench for seq_frame_tx (DATA_W=8, GAP_BITS=2). Inputs are driven
// and outputs sampled 1 time unit after each rising edge. A small 1011
// detector model watches the serial stream for the loopback scenario.
// ---------------------------------------------------------------------------
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       out_bit;
  logic       out_valid;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  seq_frame_tx #(
    .DATA_W   (8),
    .GAP_BITS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Overlapping 1011 detector on valid bits; seq_seen is registered.
  logic [3:0] det_hist;
  logic       seq_seen;
  always @(posedge clk) begin
    if (reset) begin
      det_hist <= 4'b0000;
      seq_seen <= 1'b0;
    end else if (out_valid) begin
      det_hist <= {det_hist[2:0], out_bit};
      seq_seen <= ({det_hist[2:0], out_bit} == 4'b1011);
    end else begin
      seq_seen <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake one word in the current (idle) cycle and record the frame.
  task automatic send_frame(input logic [7:0] d, output logic [63:0] bits,
                            output int len, output int done_at, output int done_cnt);
    data_in    = d;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    bits     = '0;
    len      = 0;
    done_at  = -1;
    done_cnt = 0;
    while (out_valid && len < 64) begin
      bits = {bits[62:0], out_bit};
      len++;
      if (frame_done) begin
        done_cnt++;
        done_at = len;
      end
      step();
    end
    $display("frame data=%h len=%0d done_at=%0d", d, len, done_at);
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'hA5;
    repeat (3) step();
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %b expected 0", data_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_in_reset: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_in_reset: got %b expected 0", out_valid); end
    reset      = 1'b0;
    data_valid = 1'b0;
    #0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_bit !== 1'b0) begin errors++; $display("FAIL rst_out_bit: got %b expected 0", out_bit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", data_ready); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_handshake: busy=%b expected 0", busy); end
    $display("reset sequence done");
  endtask

  task automatic test_a5();
    logic [63:0] bits;
    int len, done_at, done_cnt;
    send_frame(8'hA5, bits, len, done_at, done_cnt);
    checks++; if (len !== 15) begin errors++; $display("FAIL a5_len: got %0d expected 15", len); end
    checks++; if (bits[14:0] !== 15'b101110100010100) begin errors++; $display("FAIL a5_bits: got %b expected 101110100010100", bits[14:0]); end
    checks++; if (done_at !== 15) begin errors++; $display("FAIL a5_done_pos: got %0d expected 15", done_at); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL a5_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL a5_ready_after: got %b expected 1", data_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after: got %b expected 0", busy); end
    checks++; if (out_bit !== 1'b0) begin errors++; $display("FAIL a5_bit_idle: got %b expected 0", out_bit); end
  endtask

  task automatic test_b6();
    logic [63:0] bits;
    int len, done_at, done_cnt, n1011;
    send_frame(8'hB6, bits, len, done_at, done_cnt);
    checks++; if (len !== 16) begin errors++; $display("FAIL b6_len: got %0d expected 16", len); end
    checks++; if (bits[15:0] !== 16'b1011101010011000) begin errors++; $display("FAIL b6_bits: got %b expected 1011101010011000", bits[15:0]); end
    checks++; if (done_at !== 16) begin errors++; $display("FAIL b6_done_pos: got %0d expected 16", done_at); end
    n1011 = 0;
    for (int i = 0; i <= 12; i++) begin
      if (bits[15-i -: 4] == 4'b1011) n1011++;
    end
    checks++; if (n1011 !== 1) begin errors++; $display("FAIL b6_1011_count: got %0d expected 1", n1011); end
  endtask

  task automatic test_back_to_back();
    logic [29:0] vv, bv, dv;
    logic [29:0] exp_v, exp_b, exp_d;
    exp_v = {14'h3FFF, 1'b0, 14'h3FFF, 1'b0};
    exp_b = {14'b10111111111100, 1'b0, 14'b10110000000000, 1'b0};
    exp_d = {13'b0, 1'b1, 1'b0, 13'b0, 1'b1, 1'b0};
    vv = '0; bv = '0; dv = '0;
    data_in    = 8'hFF;
    data_valid = 1'b1;
    step();
    for (int k = 1; k <= 30; k++) begin
      vv = {vv[28:0], out_valid};
      bv = {bv[28:0], out_bit};
      dv = {dv[28:0], frame_done};
      if (k == 15) begin
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_gap: got %b expected 1", data_ready); end
      end
      if (k == 2)  data_in = 8'h3C;  // ignored while busy
      if (k == 14) data_in = 8'h00;  // picked up at the idle-cycle handshake
      if (k == 16) data_valid = 1'b0;
      step();
    end
    $display("back_to_back FF,00 valid=%b", vv);
    checks++; if (vv !== exp_v) begin errors++; $display("FAIL b2b_valid: got %b expected %b", vv, exp_v); end
    checks++; if (bv !== exp_b) begin errors++; $display("FAIL b2b_bits: got %b expected %b", bv, exp_b); end
    checks++; if (dv !== exp_d) begin errors++; $display("FAIL b2b_done: got %b expected %b", dv, exp_d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] bits;
    int len, done_at, done_cnt, stray;
    data_in    = 8'hA5;
    data_valid = 1'b1;
    step();              // T+1
    data_valid = 1'b0;
    repeat (6) step();   // T+7: third payload bit
    checks++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin errors++; $display("FAIL mid_pre_state: valid=%b bit=%b expected 1 1", out_valid, out_bit); end
    reset = 1'b1;
    step();              // T+8
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_bit !== 1'b0) begin errors++; $display("FAIL mid_out_bit: got %b expected 0", out_bit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_frame_done: got %b expected 0", frame_done); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 0", data_ready); end
    reset = 1'b0;
    #0;
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", data_ready); end
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid || frame_done) stray++;
      step();
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL mid_stray_output: got %0d cycles expected 0", stray); end
    send_frame(8'hFF, bits, len, done_at, done_cnt);
    checks++; if (len !== 14) begin errors++; $display("FAIL mid_ff_len: got %0d expected 14", len); end
    checks++; if (bits[13:0] !== 14'b10111111111100) begin errors++; $display("FAIL mid_ff_bits: got %b expected 10111111111100", bits[13:0]); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mid_ff_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    int k, pulses, pos;
    for (int f = 0; f < 20; f++) begin
      d          = 8'($urandom_range(0, 255));
      data_in    = d;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      k = 1; pulses = 0; pos = -1;
      while (out_valid && k < 64) begin
        if (seq_seen) begin pulses++; pos = k; end
        step();
        k++;
      end
      if (seq_seen) pulses++;
      $display("loopback frame %0d data=%h len=%0d seq_pos=%0d", f, d, k - 1, pos);
      checks++; if (k < 15 || k >= 64) begin errors++; $display("FAIL loop_len[%0d]: got %0d expected 14..63", f, k - 1); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL loop_pulses[%0d]: got %0d expected 1", f, pulses); end
      checks++; if (pos !== 5) begin errors++; $display("FAIL loop_pos[%0d]: got %0d expected 5", f, pos); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_a5();
    test_b6();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter that produces the bit stream consumed by the team's 1011 sequence detector.
- Accepts a parallel payload word through a valid/ready handshake and emits, one bit per clock, a fixed 1011 preamble, then the payload MSB-first, then a run of idle zeros.
- Zero-stuffs the payload so that 1011 appears only as the preamble.
- Used as the stimulus and loopback source in front of the detector.

Parameters:
- DATA_W, 8, payload width in bits (range 1..32).
- GAP_BITS, 2, number of trailing zero bits per frame (range 1..15; 0 is not allowed).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  payload word; sampled on the handshake cycle.
- data_valid  input  1  payload available.
- data_ready  output  1  transmitter can accept a payload.
- out_bit  output  1  serial bit; registered.
- out_valid  output  1  out_bit belongs to a frame; registered.
- busy  output  1  frame in progress (state != IDLE).
- frame_done  output  1  single-cycle pulse on the last gap bit.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset values: state=IDLE, out_bit=0, out_valid=0, busy=0, frame_done=0, bit history=000. data_ready=0 while reset is high.
- data_ready = (state==IDLE) && !reset. The handshake occurs on a cycle where data_valid && data_ready; data_in is latched into a shift register and the history is cleared to 000.
- States: IDLE, PREAMBLE, PAYLOAD, STUFF, GAP. All outputs come from registers updated in the same edge as state.
- Frame timing, handshake at cycle T:
  - T+1..T+4: PREAMBLE drives out_bit = 1,0,1,1 with out_valid=1.
  - T+5 onward: PAYLOAD drives data bits MSB-first, one per cycle, with STUFF cycles inserted as below.
  - After the last payload bit: GAP drives GAP_BITS cycles of out_bit=0 with out_valid=1.
  - frame_done=1 only on the last GAP cycle.
  - Next cycle: IDLE with out_valid=0, out_bit=0, data_ready=1.
- Back-to-back: the earliest next handshake is the first IDLE cycle. No bubble is required beyond that cycle.
- Bit history: a 3-bit shift register of every emitted bit (preamble, payload and stuff bits; gap bits are not tracked). After the preamble it holds 011.
- Stuffing rule: if a payload bit (not the final one) makes history==101, the next cycle is STUFF, emitting out_bit=0 with out_valid=1. The next payload bit follows after STUFF.
  - STUFF never consumes payload and may occur repeatedly.
  - No stuff bit follows the final payload bit; the gap zeros cover that case.
  - Guarantee: 1011 appears in a frame only at the preamble.
- Frame length = 4 + DATA_W + stuff_count + GAP_BITS cycles.
- out_bit=0 whenever out_valid=0.
- data_valid asserted while busy has no effect; data_in changes while busy have no effect.
- Reset mid-frame: the frame is abandoned. On the next cycle all outputs are at reset values, with no frame_done and no further bits. data_ready returns on the first cycle reset is low.
- Reset and data_valid together: no handshake occurs.

Test Plan:
- Reset 3 cycles, then idle → out_valid=0, out_bit=0, busy=0, data_ready=1 on the first cycle after reset drops.
- data_in=8'hA5 handshaked at T → out_bit T+1..T+15 = 1011 1 0 1 0 0 0 1 0 1 0 0 (one stuff at T+8). out_valid=1 over T+1..T+15, frame_done at T+15 only, data_ready=1 at T+16.
- data_in=8'hB6 → payload section 1 0 1 0 1 0 0 1 1 0 (stuffs after bit 3 and bit 4, 10 cycles). Total frame 16 cycles. Scanning the stream shows exactly one 1011, at the preamble.
- data_in=8'hFF, then 8'h00 held valid back-to-back → each frame is 14 cycles with no stuffing. Second handshake on the first IDLE cycle; out_valid low for exactly that one cycle between frames.
- Reset asserted at the 3rd payload bit of 8'hA5 → next cycle out_valid=0, out_bit=0, busy=0, no frame_done pulse. A new frame 8'hFF after reset starts cleanly with the 1011 preamble.
- Loopback: feed out_bit into the 1011 detector for 20 random payloads → seq_seen pulses exactly once per frame, on the cycle after the fourth preamble bit.
